// File: rtl/pot_weight_encoder.sv
// pot_weight_encoder: quantises signed 8-bit weights to power-of-two codes
// (sign, zero flag, shift) and buffers them in a show-ahead FIFO feeding the
// top edge of one systolic-array column. m_last tags every FRAME_LEN-th code.
module pot_weight_encoder #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int MAX_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_weight,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_code,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [7:0]             clamp_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [FW-1:0] LAST_IDX    = FW'(FRAME_LEN - 1);
  localparam logic [3:0]    SHIFT_LIMIT = 4'(MAX_SHIFT);

  // ---------------------------------------------------------------------------
  // Encoder (combinational on s_weight)
  // ---------------------------------------------------------------------------
  logic [7:0] mag;
  logic [8:1] seen;          // seen[i] = any magnitude bit set at or above i
  logic [7:0] lead_onehot;   // one-hot position of the leading one
  logic [2:0] lead_idx;
  logic       round_up;
  logic [3:0] shift_raw;
  logic       enc_clamp;
  logic [7:0] enc_code;

  // -128 negates to 8'h80, which is exactly the unsigned magnitude 128
  assign mag     = s_weight[7] ? (8'd0 - s_weight) : s_weight;
  assign seen[8] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lead
      assign lead_onehot[gi] = mag[gi] & ~seen[gi+1];
      if (gi > 0) begin : g_seen
        assign seen[gi] = seen[gi+1] | mag[gi];
      end
    end
  endgenerate

  // Round half up: the bit just below the leading one decides the next power
  assign round_up = |(lead_onehot[7:1] & mag[6:0]);

  // Binary-encode the leading-one position
  always_comb begin
    lead_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (lead_onehot[i]) lead_idx = 3'(i);
    end
  end

  assign shift_raw = {1'b0, lead_idx} + {3'b000, round_up};
  assign enc_clamp = (mag != 8'd0) && (shift_raw > SHIFT_LIMIT);

  // Assemble the code; a zero weight carries only the zero flag
  always_comb begin
    enc_code = 8'h40;
    if (mag != 8'd0) begin
      enc_code = {s_weight[7], 3'b000, (enc_clamp ? SHIFT_LIMIT : shift_raw)};
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake / control
  // ---------------------------------------------------------------------------
  logic          s1_valid_reg;
  logic [7:0]    s1_code_reg;
  logic          s1_clamp_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] fifo_cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic [7:0]    clamp_cnt_reg;
  logic [7:0]    mem [DEPTH];

  logic fifo_full;
  logic push;
  logic pop;
  logic accept;

  // A full FIFO blocks the push even when a pop happens in the same cycle, so
  // s_ready never depends combinationally on m_ready.
  assign fifo_full = (fifo_cnt_reg == FULL_CNT);
  assign push      = s1_valid_reg & ~fifo_full;
  assign m_valid   = (fifo_cnt_reg != '0);
  assign pop       = m_valid & m_ready;
  assign s_ready   = ~s1_valid_reg | ~fifo_full;
  assign accept    = s_valid & s_ready;

  assign fifo_cnt  = fifo_cnt_reg;
  assign clamp_cnt = clamp_cnt_reg;
  assign m_last    = m_valid & (frame_cnt_reg == LAST_IDX);
  // Head is read directly so a code written on one edge is visible right after it
  assign m_code    = m_valid ? mem[rd_ptr_reg] : 8'h00;

  // Stage S1: holds one encoded weight; reloads in the same cycle it pushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= 8'h00;
      s1_clamp_reg <= 1'b0;
    end else if (clear) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_code_reg  <= enc_code;
      s1_clamp_reg <= enc_clamp;
    end else if (push) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // FIFO storage: contents need no reset because m_code is gated by occupancy
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= s1_code_reg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Frame position of the head code, advanced on every pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg <= '0;
    end else if (clear) begin
      frame_cnt_reg <= '0;
    end else if (pop) begin
      if (frame_cnt_reg == LAST_IDX) frame_cnt_reg <= '0;
      else                           frame_cnt_reg <= frame_cnt_reg + FW'(1);
    end
  end

  // Saturating count of clamped codes entering the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clamp_cnt_reg <= 8'd0;
    end else if (clear) begin
      clamp_cnt_reg <= 8'd0;
    end else if (push && s1_clamp_reg && (clamp_cnt_reg != 8'hFF)) begin
      clamp_cnt_reg <= clamp_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_pot_weight_encoder.sv
// Directed bench for pot_weight_encoder: encode sweep, clamping, backpressure,
// framing, throughput and flush by clear / asynchronous reset.
module tb_pot_weight_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_weight;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_code;
  logic       m_last;
  logic [3:0] fifo_cnt;
  logic [7:0] clamp_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pot_weight_encoder #(.DEPTH(8), .FRAME_LEN(4), .MAX_SHIFT(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_weight (s_weight),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_code   (m_code),
    .m_last   (m_last),
    .fifo_cnt (fifo_cnt),
    .clamp_cnt(clamp_cnt)
  );

  // Present one weight for one clock; acc reports whether it was accepted
  task automatic drive_cycle(input logic v, input logic [7:0] w, output logic acc);
    s_valid  = v;
    s_weight = w;
    acc      = v && s_ready;
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
  endtask

  task automatic do_clear();
    clear   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_weight = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_code !== 8'h00) begin errors++; $display("FAIL reset_m_code got %h exp 00", m_code); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_fifo_cnt got %0d exp 0", fifo_cnt); end
    checks++; if (clamp_cnt !== 8'd0) begin errors++; $display("FAIL reset_clamp_cnt got %0d exp 0", clamp_cnt); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_m_valid got %b exp 0", m_valid); end
    $display("test_reset done");
  endtask

  task automatic test_encode();
    logic [7:0] w [6];
    logic [7:0] e [6];
    logic acc;
    int ni = 0;
    int no = 0;
    w = '{8'h05, 8'h06, 8'hFA, 8'h00, 8'h01, 8'hFF};
    e = '{8'h02, 8'h03, 8'h83, 8'h40, 8'h00, 8'h80};
    do_clear();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && no < 6; cyc++) begin
      if (m_valid) begin
        checks++;
        if (m_code !== e[no]) begin errors++; $display("FAIL encode[%0d] w=%h got %h exp %h", no, w[no], m_code, e[no]); end
        else $display("encode w=%h code=%h", w[no], m_code);
        no++;
      end
      drive_cycle(ni < 6, w[(ni < 6) ? ni : 0], acc);
      if (acc) ni++;
    end
    checks++; if (no != 6) begin errors++; $display("FAIL encode_count got %0d exp 6", no); end
  endtask

  task automatic test_clamp();
    logic [7:0] w [3];
    logic [7:0] e [3];
    logic acc;
    int ni = 0;
    int no = 0;
    w = '{8'h60, 8'h7F, 8'h80};
    e = '{8'h06, 8'h06, 8'h86};
    do_clear();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && no < 3; cyc++) begin
      if (m_valid) begin
        checks++;
        if (m_code !== e[no]) begin errors++; $display("FAIL clamp_code[%0d] got %h exp %h", no, m_code, e[no]); end
        else $display("clamp w=%h code=%h", w[no], m_code);
        no++;
      end
      drive_cycle(ni < 3, w[(ni < 3) ? ni : 0], acc);
      if (acc) ni++;
    end
    checks++; if (no != 3) begin errors++; $display("FAIL clamp_code_count got %0d exp 3", no); end
    checks++; if (clamp_cnt !== 8'd3) begin errors++; $display("FAIL clamp_cnt3 got %0d exp 3", clamp_cnt); end
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 8'h7F, acc);
    repeat (3) drive_cycle(1'b0, 8'h00, acc);
    checks++; if (clamp_cnt !== 8'd255) begin errors++; $display("FAIL clamp_cnt_sat got %0d exp 255", clamp_cnt); end
    else $display("clamp saturated clamp_cnt=%0d", clamp_cnt);
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL clamp_drain fifo_cnt got %0d exp 0", fifo_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [12];
    logic [7:0] e [12];
    logic acc;
    int nacc = 0;
    int no = 0;
    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00, 8'hFF, 8'hFE, 8'hFC, 8'hF8};
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h40, 8'h80, 8'h81, 8'h82, 8'h83};
    do_clear();
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(1'b1, w[nacc], acc);
      if (acc) nacc++;
    end
    checks++; if (nacc != 9) begin errors++; $display("FAIL bp_accepted got %0d exp 9", nacc); end
    checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL bp_fifo_cnt got %0d exp 8", fifo_cnt); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got %b exp 0", s_ready); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid got %b exp 1", m_valid); end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && no < 9; cyc++) begin
      if (m_valid) begin
        checks++;
        if (m_code !== e[no]) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", no, m_code, e[no]); end
        else $display("backpressure pop %0d code=%h", no, m_code);
        no++;
      end
      drive_cycle(1'b0, 8'h00, acc);
    end
    checks++; if (no != 9) begin errors++; $display("FAIL bp_pop_count got %0d exp 9", no); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_code m_valid got %b exp 0", m_valid); end
  endtask

  task automatic test_frame();
    logic [7:0] w [8];
    logic [7:0] e [8];
    logic acc;
    int ni = 0;
    int no = 0;
    int last_pops = 0;
    int stalled_last = 0;
    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'hFF, 8'hFE};
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h80, 8'h81};
    do_clear();
    for (int cyc = 0; cyc < 100 && no < 8; cyc++) begin
      m_ready = ((cyc % 3) == 2);
      if (m_valid) begin
        checks++;
        if (m_code !== e[no] || m_last !== ((no % 4) == 3)) begin
          errors++;
          $display("FAIL frame[%0d] got code=%h last=%b exp code=%h last=%b", no, m_code, m_last, e[no], ((no % 4) == 3));
        end
        if (m_last && !m_ready) stalled_last++;
        if (m_ready) begin
          if (m_last) last_pops++;
          $display("frame pop %0d code=%h last=%b", no, m_code, m_last);
          no++;
        end
      end
      drive_cycle(ni < 8, w[(ni < 8) ? ni : 0], acc);
      if (acc) ni++;
    end
    checks++; if (no != 8) begin errors++; $display("FAIL frame_pop_count got %0d exp 8", no); end
    checks++; if (last_pops != 2) begin errors++; $display("FAIL frame_last_pops got %0d exp 2", last_pops); end
    checks++; if (stalled_last == 0) begin errors++; $display("FAIL frame_last_hold got %0d stalled samples exp >0", stalled_last); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [8];
    logic [7:0] e [8];
    logic acc;
    w = '{8'h05, 8'h06, 8'hFA, 8'h00, 8'h01, 8'hFF, 8'h60, 8'h03};
    e = '{8'h02, 8'h03, 8'h83, 8'h40, 8'h00, 8'h80, 8'h06, 8'h02};
    do_clear();
    m_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      drive_cycle(j < 10, w[j % 8], acc);
      if (j < 10) begin
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got %b exp 1", j, acc); end
      end
      if (j == 0) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency m_valid got %b exp 0", m_valid); end
      end else if (j <= 10) begin
        checks++;
        if (m_valid !== 1'b1 || m_code !== e[(j - 1) % 8] || fifo_cnt > 4'd1) begin
          errors++;
          $display("FAIL b2b[%0d] got valid=%b code=%h cnt=%0d exp valid=1 code=%h cnt<=1", j, m_valid, m_code, fifo_cnt, e[(j - 1) % 8]);
        end else $display("b2b cycle %0d code=%h cnt=%0d", j, m_code, fifo_cnt);
      end else begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained m_valid got %b exp 0", m_valid); end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] fw [6];
    logic [7:0] nw [4];
    logic [7:0] ne [4];
    logic acc;
    fw = '{8'h7F, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    nw = '{8'h01, 8'h02, 8'h04, 8'h08};
    ne = '{8'h00, 8'h01, 8'h02, 8'h03};
    for (int mode = 0; mode < 2; mode++) begin
      int no = 0;
      int ni = 0;
      do_clear();
      // two pops so the frame counter is mid-frame before the flush
      m_ready = 1'b1;
      for (int j = 0; j < 4; j++) drive_cycle(j < 2, 8'h01, acc);
      m_ready = 1'b0;
      for (int j = 0; j < 6; j++) drive_cycle(1'b1, fw[j], acc);
      checks++; if (fifo_cnt !== 4'd5 || clamp_cnt !== 8'd1) begin
        errors++; $display("FAIL flush%0d_prefill got cnt=%0d clamp=%0d exp cnt=5 clamp=1", mode, fifo_cnt, clamp_cnt);
      end
      if (mode == 0) begin
        clear = 1'b1;
        drive_cycle(1'b1, 8'h22, acc);
        clear = 1'b0;
      end else begin
        #2 reset = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || fifo_cnt !== 4'd0) begin
          errors++; $display("FAIL flush1_async got valid=%b cnt=%0d exp valid=0 cnt=0", m_valid, fifo_cnt);
        end
        s_valid = 1'b1; s_weight = 8'h22;
        @(posedge clk);
        #1;
        reset = 1'b1; s_valid = 1'b0;
      end
      checks++;
      if (m_valid !== 1'b0 || fifo_cnt !== 4'd0 || clamp_cnt !== 8'd0 || s_ready !== 1'b1 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL flush%0d_state got valid=%b cnt=%0d clamp=%0d ready=%b last=%b exp 0 0 0 1 0", mode, m_valid, fifo_cnt, clamp_cnt, s_ready, m_last);
      end else $display("flush mode %0d cleared", mode);
      drive_cycle(1'b0, 8'h00, acc);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush%0d_dropped m_valid got %b exp 0", mode, m_valid); end
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && no < 4; cyc++) begin
        if (m_valid) begin
          checks++;
          if (m_code !== ne[no] || m_last !== (no == 3)) begin
            errors++;
            $display("FAIL flush%0d_frame[%0d] got code=%h last=%b exp code=%h last=%b", mode, no, m_code, m_last, ne[no], (no == 3));
          end else $display("flush mode %0d pop %0d code=%h last=%b", mode, no, m_code, m_last);
          no++;
        end
        drive_cycle(ni < 4, nw[(ni < 4) ? ni : 0], acc);
        if (acc) ni++;
      end
      checks++; if (no != 4) begin errors++; $display("FAIL flush%0d_pop_count got %0d exp 4", mode, no); end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_clamp();
    test_backpressure();
    test_frame();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
